// File: rtl/blob_pkg.sv
// Shared types and defaults for the Blob frame sequencer.
package blob_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        WAIT_SOF = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam int H_ACT_DEF       = 640;
    localparam int V_ACT_DEF       = 480;
    localparam int CLR_CYC_DEF     = 2;
    localparam int TIMEOUT_CYC_DEF = 200000;
    localparam int CNT_W_DEF       = 8;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blob_frame_cnt.sv
// Pixel counter for one frame: synchronous clear, count enable and a flag
// that is high while the next counted pixel completes the frame.
module blob_frame_cnt #(
    parameter int TOTAL = 640 * 480,
    parameter int W     = $clog2(640 * 480 + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    logic [W-1:0] r_cnt;

    // Count forwarded pixels; saturate at TOTAL so the counter never wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != W'(TOTAL))) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_last = (r_cnt == W'(TOTAL - 1));

endmodule

// File: rtl/blob_frame_ctrl.sv
// Per-frame sequencer for the Blob connected-component counter: clears Blob,
// aligns to start-of-frame, forwards one full frame of binary pixels, then
// waits (bounded) for Blob's result and reports it.
module blob_frame_ctrl
    import blob_pkg::*;
#(
    parameter int H_ACT       = H_ACT_DEF,
    parameter int V_ACT       = V_ACT_DEF,
    parameter int CLR_CYC     = CLR_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_continuous,
    input  logic             i_abort,
    input  logic             i_pix_valid,
    input  logic             i_pix_bin,
    input  logic             i_sof,
    output logic             o_blob_rst,
    output logic             o_blob_valid,
    output logic             o_blob_seq,
    input  logic             i_blob_valid,
    input  logic [CNT_W-1:0] i_blob_count,
    output logic [CNT_W-1:0] o_count,
    output logic             o_count_valid,
    output logic             o_busy,
    output logic             o_err_short,
    output logic             o_timeout
);

    localparam int TOTAL = H_ACT * V_ACT;
    localparam int PIX_W = $clog2(TOTAL + 1);
    localparam int TO_W  = bits_for(TIMEOUT_CYC);
    localparam int CLR_W = bits_for(CLR_CYC);

    state_t           r_state;
    logic [CLR_W-1:0] r_clr_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_blob_rst;
    logic             r_blob_valid;
    logic             r_blob_seq;
    logic [CNT_W-1:0] r_count;
    logic             r_count_valid;
    logic             r_busy;
    logic             r_err_short;
    logic             r_timeout;

    logic             w_fwd;
    logic             w_cnt_clr;
    logic             w_last;

    // A pixel is forwarded on the SOF pixel in WAIT_SOF, or on any non-SOF
    // pixel in STREAM; abort suppresses forwarding.
    assign w_fwd = !i_abort && i_pix_valid &&
                   (((r_state == WAIT_SOF) && i_sof) ||
                    ((r_state == STREAM) && !i_sof));

    // Counter is held at zero outside the frame, so it is clean on entry.
    assign w_cnt_clr = (r_state != WAIT_SOF) && (r_state != STREAM);

    blob_frame_cnt #(
        .TOTAL (TOTAL),
        .W     (PIX_W)
    ) u_pix_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_fwd),
        .o_last (w_last)
    );

    // Sequencer FSM with all outputs registered from the next-state decision.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_clr_cnt     <= '0;
            r_to_cnt      <= '0;
            r_blob_rst    <= 1'b1;
            r_blob_valid  <= 1'b0;
            r_blob_seq    <= 1'b0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_err_short   <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_blob_valid  <= w_fwd;
            r_blob_seq    <= w_fwd & i_pix_bin;
            r_count_valid <= 1'b0;
            r_err_short   <= 1'b0;
            r_timeout     <= 1'b0;
            if (i_abort) begin
                r_state    <= IDLE;
                r_blob_rst <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_state    <= CLEAR;
                            r_clr_cnt  <= '0;
                            r_blob_rst <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_blob_rst <= 1'b0;
                            r_busy     <= 1'b0;
                        end
                    end
                    CLEAR: begin
                        if (r_clr_cnt == CLR_W'(CLR_CYC - 1)) begin
                            r_state    <= WAIT_SOF;
                            r_blob_rst <= 1'b0;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + CLR_W'(1);
                        end
                    end
                    WAIT_SOF: begin
                        if (i_pix_valid && i_sof) begin
                            r_state  <= w_last ? DRAIN : STREAM;
                            r_to_cnt <= '0;
                        end
                    end
                    STREAM: begin
                        if (i_pix_valid) begin
                            if (i_sof) begin
                                // Early SOF: frame was short, restart cleanly.
                                r_err_short <= 1'b1;
                                r_state     <= CLEAR;
                                r_clr_cnt   <= '0;
                                r_blob_rst  <= 1'b1;
                            end else if (w_last) begin
                                r_state  <= DRAIN;
                                r_to_cnt <= '0;
                            end
                        end
                    end
                    DRAIN: begin
                        // A result arriving on the last allowed cycle still wins.
                        if (i_blob_valid) begin
                            r_count       <= i_blob_count;
                            r_count_valid <= 1'b1;
                            r_state       <= DONE;
                        end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                            r_timeout <= 1'b1;
                            r_state   <= IDLE;
                            r_busy    <= 1'b0;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                    DONE: begin
                        if (i_continuous) begin
                            r_state    <= CLEAR;
                            r_clr_cnt  <= '0;
                            r_blob_rst <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_blob_rst <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_blob_rst    = r_blob_rst;
    assign o_blob_valid  = r_blob_valid;
    assign o_blob_seq    = r_blob_seq;
    assign o_count       = r_count;
    assign o_count_valid = r_count_valid;
    assign o_busy        = r_busy;
    assign o_err_short   = r_err_short;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_blob_frame_ctrl.sv
// Bench for blob_frame_ctrl: small-frame instance checked every cycle against
// a behavioural model, plus a default-size instance for mid-stream reset.
module tb_blob_frame_ctrl;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int TOT = H * V;
    localparam int CLR = 2;
    localparam int TO  = 50;

    localparam int M_IDLE = 0, M_CLEAR = 1, M_WAIT = 2, M_STREAM = 3, M_DRAIN = 4, M_DONE = 5;

    logic       clk = 1'b0;
    logic       rst, start, cont, abort, pv, bin, sof, bv;
    logic [7:0] bcnt;
    logic       o_blob_rst, o_blob_valid, o_blob_seq, o_count_valid, o_busy, o_err_short, o_timeout;
    logic [7:0] o_count;

    logic       b_rst, b_start, b_pv, b_bin, b_sof;
    logic       b_o_blob_rst, b_o_blob_valid, b_o_blob_seq, b_o_count_valid, b_o_busy, b_o_err_short, b_o_timeout;
    logic [7:0] b_o_count;

    always #5 clk = ~clk;

    blob_frame_ctrl #(.H_ACT(H), .V_ACT(V), .CLR_CYC(CLR), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_continuous(cont), .i_abort(abort),
        .i_pix_valid(pv), .i_pix_bin(bin), .i_sof(sof),
        .o_blob_rst(o_blob_rst), .o_blob_valid(o_blob_valid), .o_blob_seq(o_blob_seq),
        .i_blob_valid(bv), .i_blob_count(bcnt),
        .o_count(o_count), .o_count_valid(o_count_valid), .o_busy(o_busy),
        .o_err_short(o_err_short), .o_timeout(o_timeout));

    blob_frame_ctrl dut_big (
        .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_continuous(1'b0), .i_abort(1'b0),
        .i_pix_valid(b_pv), .i_pix_bin(b_bin), .i_sof(b_sof),
        .o_blob_rst(b_o_blob_rst), .o_blob_valid(b_o_blob_valid), .o_blob_seq(b_o_blob_seq),
        .i_blob_valid(1'b0), .i_blob_count(8'd0),
        .o_count(b_o_count), .o_count_valid(b_o_count_valid), .o_busy(b_o_busy),
        .o_err_short(b_o_err_short), .o_timeout(b_o_timeout));

    int n_pass = 0, n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int         cyc = 0;
    int         m_mode = M_IDLE, m_clr_left = 0, m_pix = 0, m_age = 0;
    bit         m_live = 0;
    logic       e_brst, e_val, e_seq, e_cv, e_busy, e_err, e_to;
    logic [7:0] e_cnt;

    task automatic model_step();
        cyc++;
        if (rst) begin
            m_mode = M_IDLE; m_live = 1;
            e_brst = 1; e_val = 0; e_seq = 0; e_cnt = 0; e_cv = 0; e_busy = 0; e_err = 0; e_to = 0;
            return;
        end
        e_val = 0; e_seq = 0; e_cv = 0; e_err = 0; e_to = 0;
        if (abort) m_mode = M_IDLE;
        else case (m_mode)
            M_IDLE: if (start) begin m_mode = M_CLEAR; m_clr_left = CLR; end
            M_CLEAR: begin
                m_clr_left--;
                if (m_clr_left == 0) m_mode = M_WAIT;
            end
            M_WAIT: if (pv && sof) begin
                e_val = 1; e_seq = bin; m_pix = 1; m_age = 0;
                m_mode = (m_pix == TOT) ? M_DRAIN : M_STREAM;
            end
            M_STREAM: if (pv) begin
                if (sof) begin
                    e_err = 1; m_mode = M_CLEAR; m_clr_left = CLR;
                end else begin
                    e_val = 1; e_seq = bin; m_pix++;
                    if (m_pix == TOT) begin m_mode = M_DRAIN; m_age = 0; end
                end
            end
            M_DRAIN: begin
                m_age++;
                if (bv) begin e_cnt = bcnt; e_cv = 1; m_mode = M_DONE; end
                else if (m_age == TO) begin e_to = 1; m_mode = M_IDLE; end
            end
            M_DONE: if (cont) begin m_mode = M_CLEAR; m_clr_left = CLR; end
                    else m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        e_brst = (m_mode == M_CLEAR);
        e_busy = (m_mode != M_IDLE);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare process + event tallies ----------------
    int n_fwd = 0, n_cv = 0, n_err = 0, n_to = 0, n_runs = 0;
    int run = 0, last_run = 0, last_fwd_cyc = 0, to_cyc = 0;

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("cycle", {17'd0, o_blob_rst, o_blob_valid, o_blob_seq, o_count, o_count_valid, o_busy, o_err_short, o_timeout},
                         {17'd0, e_brst, e_val, e_seq, e_cnt, e_cv, e_busy, e_err, e_to});
            if (o_blob_valid) begin n_fwd++; last_fwd_cyc = cyc; end
            if (o_count_valid) n_cv++;
            if (o_err_short) n_err++;
            if (o_timeout) begin n_to++; to_cyc = cyc; end
            if (o_blob_rst) run++;
            else if (run > 0) begin last_run = run; n_runs++; run = 0; end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        start = 0; abort = 0; pv = 0; bin = 0; sof = 0; bv = 0;
    endtask

    task automatic wait_mode(input int m, input int budget, input string nm);
        int k = 0;
        while (m_mode != m && k < budget) begin tick(); k++; end
        n_total++;
        if (m_mode == m) n_pass++;
        else $display("FAIL %s: wait expired, model mode %0d expected %0d", nm, m_mode, m);
    endtask

    task automatic stream(input int n, input int duty, input int sof_at);
        for (int k = 0; k < n; k++) begin
            while (duty < 100 && $urandom_range(99) >= duty) begin
                pv = 0; sof = 1'($urandom_range(1)); bin = 1'($urandom_range(1)); tick();
            end
            pv = 1; bin = 1'($urandom_range(1)); sof = (k == 0) || (k == sof_at); tick();
        end
        pv = 0; sof = 0;
    endtask

    task automatic respond(input int delay, input logic [7:0] val);
        repeat (delay) tick();
        bv = 1; bcnt = val; tick(); bv = 0;
    endtask

    task automatic arm();
        start = 1; tick(); start = 0;
        wait_mode(M_WAIT, 10, "arm");
    endtask

    // ---------------- main sequence ----------------
    int f0, c0, e0, t0, r0;
    logic [7:0] v, old;

    initial begin
        rst = 1; cont = 0; bcnt = 0; idle_in();
        b_rst = 1; b_start = 0; b_pv = 0; b_bin = 0; b_sof = 0;
        tick(); tick();
        chk("rst_blob_rst", o_blob_rst, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_count", o_count, 0);
        chk("rst_valid", o_blob_valid, 0);
        rst = 0; tick();
        chk("idle_blob_rst_drop", o_blob_rst, 0);

        // 1: basic frame, count 5
        arm();
        f0 = n_fwd; c0 = n_cv;
        pv = 1; sof = 0; repeat (3) tick(); pv = 0;
        stream(TOT, 100, -1);
        wait_mode(M_DRAIN, 5, "t1_drain");
        respond(3, 8'd5);
        repeat (3) tick();
        chk("t1_fwd", n_fwd - f0, TOT);
        chk("t1_count", o_count, 5);
        chk("t1_cv", n_cv - c0, 1);
        chk("t1_busy", o_busy, 0);
        chk("t1_clr_len", last_run, CLR);

        // 2: gappy pixels, extras dropped
        arm();
        f0 = n_fwd; v = 8'($urandom_range(255));
        stream(TOT + 4, 50, -1);
        respond(2, v);
        repeat (3) tick();
        chk("t2_fwd", n_fwd - f0, TOT);
        chk("t2_count", o_count, v);

        // 3: early SOF at pixel 20, then a good frame
        arm();
        f0 = n_fwd; e0 = n_err;
        stream(25, 100, 20);
        wait_mode(M_WAIT, 10, "t3_rewait");
        chk("t3_err", n_err - e0, 1);
        chk("t3_fwd_short", n_fwd - f0, 20);
        chk("t3_clr_len", last_run, CLR);
        v = 8'($urandom_range(255));
        stream(TOT, 100, -1);
        respond(1, v);
        repeat (3) tick();
        chk("t3_count", o_count, v);
        chk("t3_fwd_total", n_fwd - f0, 20 + TOT);

        // 4: timeout, then result on the last allowed cycle
        old = o_count; t0 = n_to;
        arm();
        stream(TOT, 100, -1);
        repeat (TO + 10) tick();
        chk("t4_to_delay", to_cyc - last_fwd_cyc, TO);
        chk("t4_to_cnt", n_to - t0, 1);
        chk("t4_count_hold", o_count, old);
        chk("t4_busy", o_busy, 0);
        t0 = n_to; c0 = n_cv; v = 8'($urandom_range(255));
        arm();
        stream(TOT, 100, -1);
        for (int k = 0; k < 200 && cyc < last_fwd_cyc + TO - 1; k++) tick();
        bv = 1; bcnt = v; tick(); bv = 0;
        repeat (3) tick();
        chk("t4_late_count", o_count, v);
        chk("t4_late_no_to", n_to - t0, 0);
        chk("t4_late_cv", n_cv - c0, 1);

        // 5: continuous over 3 frames, then abort mid-stream
        cont = 1; c0 = n_cv; r0 = n_runs;
        start = 1; tick(); start = 0;
        for (int f = 0; f < 3; f++) begin
            wait_mode(M_WAIT, 10, "t5_wait");
            stream(TOT, 100, -1);
            if (f == 2) cont = 0;
            respond(1, 8'(f + 10));
        end
        repeat (4) tick();
        chk("t5_cv", n_cv - c0, 3);
        chk("t5_clears", n_runs - r0, 3);
        chk("t5_count", o_count, 12);
        arm();
        stream(10, 100, -1);
        pv = 1; abort = 1; tick(); abort = 0; pv = 0;
        chk("t5_abort_valid", o_blob_valid, 0);
        chk("t5_abort_busy", o_busy, 0);
        start = 1; abort = 1; tick(); start = 0; abort = 0; tick();
        chk("t5_start_abort_idle", o_busy, 0);

        // randomized soak against the model
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(99) < 10);
            abort = ($urandom_range(999) < 8);
            cont  = ($urandom_range(99) < 30);
            pv    = ($urandom_range(99) < 70);
            sof   = ($urandom_range(99) < 4);
            bin   = 1'($urandom_range(1));
            bv    = ($urandom_range(99) < 8);
            bcnt  = 8'($urandom_range(255));
            tick();
        end
        idle_in(); cont = 0; abort = 1; tick(); abort = 0; tick();

        // 6: default-size instance, reset mid-stream
        b_rst = 0; tick();
        b_start = 1; tick(); b_start = 0;
        repeat (4) tick();
        for (int k = 0; k < 100; k++) begin
            b_pv = 1; b_sof = (k == 0); b_bin = 1'(k & 1); tick();
        end
        @(negedge clk);
        chk("t6_mid_valid", b_o_blob_valid, 1);
        chk("t6_mid_busy", b_o_busy, 1);
        b_rst = 1; tick();
        chk("t6_blob_rst", b_o_blob_rst, 1);
        chk("t6_valid", b_o_blob_valid, 0);
        chk("t6_seq", b_o_blob_seq, 0);
        chk("t6_count", b_o_count, 0);
        chk("t6_pulses", {b_o_count_valid, b_o_err_short, b_o_timeout}, 0);
        chk("t6_busy", b_o_busy, 0);
        b_rst = 0; b_pv = 0; b_sof = 0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
